serial_word_feeder: RTL and testbench

Upstream stage for the 4-bit serial-in shift register. It accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial line `D`, which drives the shift register's `D` input directly. A one-entry holding buffer lets back-to-back words stream with no idle cycle between them. Per-bit and frame-start strobes let downstream logic tell when the shift register holds a complete word.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_word_feeder_if.sv | 37 +++
 rtl/word_hold_reg.sv | 37 +++
 rtl/serial_word_feeder.sv | 124 ++++++++++++
 tb/tb_serial_word_feeder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word feeder and the downstream shift register.
// Holds the FSM state encoding, the default word width and the bit-counter width helper.
// Contains no logic of its own, so latency and backpressure do not apply.
package serial_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Word width shared with the 4-bit serial-in shift register.
    localparam int DEFAULT_WORD_WIDTH = 4;

    // Bit-counter width for a given word width: CNT_W = $clog2(WIDTH).
    // Words are always at least 2 bits wide, so the result is at least 1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Bundles the word handshake and the serial output of serial_word_feeder.
// Pure wiring, so it adds no latency.
// in_ready is driven by the feeder and in_valid by the producer; the serial side has no backpressure.
interface serial_word_feeder_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             D;
    logic             bit_valid;
    logic             frame_start;

    // The producer of words and consumer of the serial line.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  D,
        input  bit_valid,
        input  frame_start
    );

    // The feeder itself.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output D,
        output bit_valid,
        output frame_start
    );

endinterface

// File: rtl/word_hold_reg.sv
// Holds one word that arrived while the feeder was still shifting out the previous one.
// A write is visible on dout and full the cycle after wr_en; a read clears full on the next edge.
// It has no backpressure of its own: the caller must write only while full is low.
//
// Ports: clk, rst (sync, active-high), wr_en/din (store a word), rd_en (release it),
//        dout (stored word), full (a word is held).
module word_hold_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (wr_en) begin
            data <= din;
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

    assign dout = data;

endmodule

// File: rtl/serial_word_feeder.sv
// Takes parallel words over valid/ready and emits them one bit per clock on D.
// A word accepted while idle shows its first bit on D in the next cycle. Back-to-back words stream with no gap.
// in_ready drops while the one-entry hold buffer is full and rises again on the edge that drains it.
//
// Ports: clk, rst (sync, active-high), bus (slave modport: in_data/in_valid/in_ready,
//        D, bit_valid, frame_start).
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WORD_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_word_feeder_if.slave  bus
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [WIDTH-1:0] hold_dout;
    logic [CNT_W-1:0] cnt;
    logic             hold_full;
    logic             hold_wr;
    logic             hold_rd;
    logic             xfer;
    logic             last_bit;
    logic             d_q;
    logic             bit_valid_q;
    logic             frame_start_q;

    // The bit that goes on D first for a freshly loaded word.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    assign bus.in_ready = !hold_full && !rst;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign last_bit     = (state == SER_SHIFT) && (cnt == CNT_LAST);

    // Only park a word when it cannot be loaded straight into sreg. On the last bit,
    // an incoming word bypasses the buffer.
    assign hold_wr      = xfer && (state == SER_SHIFT) && !last_bit;
    assign hold_rd      = last_bit && hold_full;

    assign sreg_shifted = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .wr_en (hold_wr),
        .rd_en (hold_rd),
        .din   (bus.in_data),
        .dout  (hold_dout),
        .full  (hold_full)
    );

    // The outputs are registered alongside sreg. d_q always equals the output-end bit
    // of the word that sreg holds in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SER_IDLE;
            sreg          <= '0;
            cnt           <= '0;
            d_q           <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (xfer) begin
                        state         <= SER_SHIFT;
                        sreg          <= bus.in_data;
                        cnt           <= '0;
                        d_q           <= lead_bit(bus.in_data);
                        bit_valid_q   <= 1'b1;
                        frame_start_q <= 1'b1;
                    end
                end
                SER_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        if (hold_full) begin
                            sreg          <= hold_dout;
                            cnt           <= '0;
                            d_q           <= lead_bit(hold_dout);
                            bit_valid_q   <= 1'b1;
                            frame_start_q <= 1'b1;
                        end else if (xfer) begin
                            sreg          <= bus.in_data;
                            cnt           <= '0;
                            d_q           <= lead_bit(bus.in_data);
                            bit_valid_q   <= 1'b1;
                            frame_start_q <= 1'b1;
                        end else begin
                            state         <= SER_IDLE;
                            sreg          <= '0;
                            cnt           <= '0;
                            d_q           <= 1'b0;
                            bit_valid_q   <= 1'b0;
                            frame_start_q <= 1'b0;
                        end
                    end else begin
                        sreg          <= sreg_shifted;
                        cnt           <= cnt + 1'b1;
                        d_q           <= lead_bit(sreg_shifted);
                        bit_valid_q   <= 1'b1;
                        frame_start_q <= 1'b0;
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    assign bus.D           = d_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
module tb_serial_word_feeder;
    import serial_pkg::*;

    localparam int W  = 4;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_word_feeder_if #(.WIDTH(W))  a_if ();
    serial_word_feeder_if #(.WIDTH(WB)) b_if ();

    serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    serial_word_feeder #(.WIDTH(WB), .LSB_FIRST(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for dut_a: the serial line must carry exactly the bits of the
    // accepted words in order. The line is busy whenever bits remain, and a new word fits
    // only when fewer than one full word of bits remain outstanding.
    bit q[$];
    int emitted = 0;
    bit acc;

    // Downstream 4-bit serial-in shift register, filled from the MSB side.
    logic [W-1:0] ds_sr;
    always @(posedge clk) ds_sr <= {a_if.D, ds_sr[W-1:1]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: decide acceptance from the model, advance, then check dut_a at the negedge.
    task automatic tick();
        logic rdy_exp, e_bv, e_d, e_fs, e_rdy;
        rdy_exp = !rst && (q.size() < W);
        acc     = a_if.in_valid && rdy_exp;
        @(posedge clk);
        if (rst) begin
            q.delete();
            emitted = 0;
        end else if (acc) begin
            for (int i = 0; i < W; i++) q.push_back(a_if.in_data[i]);
        end
        @(negedge clk);
        e_d  = 1'b0;
        e_fs = 1'b0;
        if (rst) begin
            e_bv  = 1'b0;
            e_rdy = 1'b0;
        end else begin
            e_bv = (q.size() > 0);
            if (e_bv) begin
                e_d  = q.pop_front();
                e_fs = (emitted % W == 0);
                emitted++;
            end
            e_rdy = (q.size() < W);
        end
        chk("a_bit_valid", a_if.bit_valid, e_bv);
        chk("a_D", a_if.D, e_d);
        chk("a_frame_start", a_if.frame_start, e_fs);
        chk("a_in_ready", a_if.in_ready, e_rdy);
    endtask

    initial begin
        logic [W-1:0]  words [3];
        logic [WB-1:0] wb;
        int k, bv_cnt, fs_cnt, guard;

        a_if.in_valid = 1'b0;
        a_if.in_data  = '0;
        b_if.in_valid = 1'b0;
        b_if.in_data  = '0;

        // Reset held for two cycles, then a single word 1011.
        rst = 1'b1;
        tick();
        tick();
        chk("b_reset_ready", b_if.in_ready, 1'b0);
        rst = 1'b0;
        tick();
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'b1011;
        tick();
        chk("single_acc", acc, 1'b1);
        a_if.in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        chk("downstream_1011", ds_sr, 4'b1011);
        chk("single_idle_bv", a_if.bit_valid, 1'b0);

        // Back-to-back A, 5, F with in_valid held high.
        words = '{4'hA, 4'h5, 4'hF};
        k = 0; bv_cnt = 0; fs_cnt = 0;
        a_if.in_valid = 1'b1;
        a_if.in_data  = words[0];
        for (int t = 0; t < 20; t++) begin
            tick();
            if (acc) k++;
            if (a_if.bit_valid) bv_cnt++;
            if (a_if.frame_start) fs_cnt++;
            if (k < 3) a_if.in_data = words[k];
            else a_if.in_valid = 1'b0;
        end
        chk("b2b_accepted", k, 3);
        chk("b2b_bit_cycles", bv_cnt, 12);
        chk("b2b_frames", fs_cnt, 3);

        // Direct load: in_valid only on the last-bit cycle of a word.
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'h6;
        tick();
        a_if.in_valid = 1'b0;
        guard = 0;
        while (!(a_if.bit_valid && q.size() == 0) && guard < 10) begin
            tick();
            guard++;
        end
        chk("direct_reached_last", guard < 10, 1'b1);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'($urandom);
        tick();
        chk("direct_acc", acc, 1'b1);
        chk("direct_first_bit", a_if.frame_start, 1'b1);
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset mid-word: C has sent 2 bits, 3 is in the hold buffer.
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'hC;
        tick();
        a_if.in_data  = 4'h3;
        tick();
        chk("mid_hold_acc", acc, 1'b1);
        a_if.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'h9;
        tick();
        a_if.in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        chk("downstream_9", ds_sr, 4'h9);

        // Stall: idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_D", a_if.D, 1'b0);
            chk("stall_ready", a_if.in_ready, 1'b1);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            a_if.in_valid = 1'($urandom_range(0, 1));
            a_if.in_data  = 4'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // MSB-first, 8-bit variant: 8'h81 then a random word.
        for (int n = 0; n < 2; n++) begin
            wb = (n == 0) ? 8'h81 : 8'($urandom);
            chk("b_ready_idle", b_if.in_ready, 1'b1);
            b_if.in_valid = 1'b1;
            b_if.in_data  = wb;
            tick();
            b_if.in_valid = 1'b0;
            for (int i = 0; i < WB; i++) begin
                chk("b_D", b_if.D, wb[WB-1-i]);
                chk("b_bit_valid", b_if.bit_valid, 1'b1);
                chk("b_frame_start", b_if.frame_start, (i == 0));
                tick();
            end
            chk("b_done_bv", b_if.bit_valid, 1'b0);
            chk("b_done_D", b_if.D, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
